apb_master_slave_link: RTL and testbench

//  Self-contained APB link: an APB requester FSM (master) wired to a word-addressed

---
 rtl/apb_master_slave_link.sv | 121 ++++++++++++
 tb/tb_apb_master_slave_link.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_slave_link.sv
// APB requester FSM wired to a word-addressed register-file completer on one clock.
// The internal bus (PENABLE, PRWADDR, PRWDATA, PRDATA1, PREADY) is exported for debug.
module apb_master_slave_link #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int MEM_DEPTH   = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              transfer,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PDATA,
    output logic              PENABLE,
    output logic [ADDR_W-1:0] PRWADDR,
    output logic [DATA_W-1:0] PRWDATA,
    output logic [DATA_W-1:0] PRDATA1,
    output logic              PREADY
);

    localparam int                IDX_W      = $clog2(MEM_DEPTH);
    localparam logic [3:0]        WAIT_CNT   = 4'(WAIT_STATES);
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(4 * MEM_DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic             start;
    logic             capture;
    logic             access;
    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic [3:0]       wait_cnt;
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    assign start = PSEL & transfer;

    // ------------------------------------------------------------------
    // Master FSM
    // ------------------------------------------------------------------
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_SETUP;
                    capture    = 1'b1;
                end
            end
            ST_SETUP: state_next = ST_ACCESS;
            ST_ACCESS: begin
                if (PREADY) begin
                    state_next = start ? ST_SETUP : ST_IDLE;
                    capture    = start;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state   <= ST_IDLE;
            PENABLE <= 1'b0;
            PRWADDR <= '0;
            PRWDATA <= '0;
        end else begin
            state   <= state_next;
            PENABLE <= (state_next == ST_ACCESS);
            if (capture) begin
                PRWADDR <= PADDR;
                PRWDATA <= PDATA;
            end
        end
    end

    // ------------------------------------------------------------------
    // Completer: wait-state counter, register file, read mux
    // ------------------------------------------------------------------
    assign access   = PSEL & PENABLE;
    assign PREADY   = access & (wait_cnt == WAIT_CNT);
    assign in_range = (PRWADDR < ADDR_LIMIT);
    assign idx      = PRWADDR[2 +: IDX_W];

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wait_cnt <= '0;
        end else if (!access || PREADY) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    // NOTE: the register file is architecturally cleared by reset, so it is built from resettable flops rather than a RAM macro.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (access && PREADY && PWRITE && in_range) begin
            mem[idx] <= PRWDATA;
        end
    end

    always_comb begin
        PRDATA1 = '0;
        if (access && !PWRITE && in_range) begin
            PRDATA1 = mem[idx];
        end
    end

endmodule

// File: tb/tb_apb_master_slave_link.sv
// Directed self-checking bench for apb_master_slave_link: one zero-wait-state
// instance and one two-wait-state instance sharing clock and reset.
module tb_apb_master_slave_link;

    logic        PCLK;
    logic        PRESET;

    logic        psel, transfer, pwrite;
    logic [31:0] paddr, pdata;
    logic        penable, pready;
    logic [31:0] prwaddr, prwdata, prdata1;

    logic        psel_w, transfer_w, pwrite_w;
    logic [31:0] paddr_w, pdata_w;
    logic        penable_w, pready_w;
    logic [31:0] prwaddr_w, prwdata_w, prdata1_w;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [16];

    apb_master_slave_link #(
        .DATA_W(32), .ADDR_W(32), .MEM_DEPTH(16), .WAIT_STATES(0)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel), .transfer(transfer),
        .PWRITE(pwrite), .PADDR(paddr), .PDATA(pdata), .PENABLE(penable),
        .PRWADDR(prwaddr), .PRWDATA(prwdata), .PRDATA1(prdata1), .PREADY(pready)
    );

    apb_master_slave_link #(
        .DATA_W(32), .ADDR_W(32), .MEM_DEPTH(16), .WAIT_STATES(2)
    ) dut_w (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel_w), .transfer(transfer_w),
        .PWRITE(pwrite_w), .PADDR(paddr_w), .PDATA(pdata_w), .PENABLE(penable_w),
        .PRWADDR(prwaddr_w), .PRWDATA(prwdata_w), .PRDATA1(prdata1_w), .PREADY(pready_w)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge PCLK);
        #1;
    endtask

    // Single write on the zero-wait instance; entered and left just after a rising edge.
    task automatic write0(input logic [31:0] addr, input logic [31:0] data);
        psel = 1'b1; transfer = 1'b1; pwrite = 1'b1; paddr = addr; pdata = data;
        next_cycle();
        transfer = 1'b0;
        @(negedge PCLK);
        check($sformatf("wr_setup_penable_%h", addr), {31'b0, penable}, 32'd0);
        check($sformatf("wr_setup_addr_%h", addr), prwaddr, addr);
        next_cycle();
        @(negedge PCLK);
        check($sformatf("wr_access_penable_%h", addr), {31'b0, penable}, 32'd1);
        check($sformatf("wr_access_pready_%h", addr), {31'b0, pready}, 32'd1);
        check($sformatf("wr_access_addr_%h", addr), prwaddr, addr);
        check($sformatf("wr_access_data_%h", addr), prwdata, data);
        next_cycle();
        psel = 1'b0;
        @(negedge PCLK);
        check($sformatf("wr_idle_penable_%h", addr), {31'b0, penable}, 32'd0);
        next_cycle();
    endtask

    task automatic read0(input logic [31:0] addr, input logic [31:0] exp);
        psel = 1'b1; transfer = 1'b1; pwrite = 1'b0; paddr = addr; pdata = 32'h0;
        next_cycle();
        transfer = 1'b0;
        next_cycle();
        @(negedge PCLK);
        check($sformatf("rd_pready_%h", addr), {31'b0, pready}, 32'd1);
        check($sformatf("rd_data_%h", addr), prdata1, exp);
        next_cycle();
        psel = 1'b0;
        next_cycle();
    endtask

    initial begin
        PRESET = 1'b1;
        psel = 0; transfer = 0; pwrite = 0; paddr = 0; pdata = 0;
        psel_w = 0; transfer_w = 0; pwrite_w = 0; paddr_w = 0; pdata_w = 0;
        for (int i = 0; i < 16; i++) model[i] = 32'h0;

        // T1: reset values
        #10;
        check("rst_penable", {31'b0, penable}, 32'd0);
        check("rst_pready", {31'b0, pready}, 32'd0);
        check("rst_prwaddr", prwaddr, 32'h0);
        check("rst_prwdata", prwdata, 32'h0);
        check("rst_prdata1", prdata1, 32'h0);
        check("rst_penable_w", {31'b0, penable_w}, 32'd0);
        next_cycle();
        PRESET = 1'b0;
        next_cycle();

        // T2: four single writes
        write0(32'h0, 32'h00000309); model[0] = 32'h00000309;
        write0(32'h4, 32'h28122023); model[1] = 32'h28122023;
        write0(32'h8, 32'h416c656b); model[2] = 32'h416c656b;
        write0(32'hC, 32'h4c656500); model[3] = 32'h4c656500;

        // T3: readback
        read0(32'h0, 32'h00000309);
        read0(32'h4, 32'h28122023);
        read0(32'h8, 32'h416c656b);
        read0(32'hC, 32'h4c656500);

        // T4: back-to-back writes to 0x14 then 0x18
        psel = 1'b1; transfer = 1'b1; pwrite = 1'b1; paddr = 32'h14; pdata = 32'h11112222;
        next_cycle();
        paddr = 32'h18; pdata = 32'h33334444;
        @(negedge PCLK);
        check("b2b_setup1_addr", prwaddr, 32'h14);
        next_cycle();
        @(negedge PCLK);
        check("b2b_access1_penable", {31'b0, penable}, 32'd1);
        check("b2b_access1_addr", prwaddr, 32'h14);
        check("b2b_access1_data", prwdata, 32'h11112222);
        next_cycle();
        transfer = 1'b0;
        @(negedge PCLK);
        check("b2b_setup2_penable", {31'b0, penable}, 32'd0);
        check("b2b_setup2_addr", prwaddr, 32'h18);
        check("b2b_setup2_data", prwdata, 32'h33334444);
        next_cycle();
        @(negedge PCLK);
        check("b2b_access2_penable", {31'b0, penable}, 32'd1);
        check("b2b_access2_pready", {31'b0, pready}, 32'd1);
        next_cycle();
        psel = 1'b0;
        @(negedge PCLK);
        check("b2b_idle_penable", {31'b0, penable}, 32'd0);
        next_cycle();
        model[5] = 32'h11112222;
        model[6] = 32'h33334444;
        read0(32'h14, 32'h11112222);
        read0(32'h18, 32'h33334444);

        // T5: two wait states, write then read 0x10
        psel_w = 1'b1; transfer_w = 1'b1; pwrite_w = 1'b1; paddr_w = 32'h10; pdata_w = 32'hDEADBEEF;
        next_cycle();
        transfer_w = 1'b0;
        @(negedge PCLK);
        check("ws_setup_penable", {31'b0, penable_w}, 32'd0);
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            @(negedge PCLK);
            check($sformatf("ws_wr_penable_c%0d", c), {31'b0, penable_w}, 32'd1);
            check($sformatf("ws_wr_pready_c%0d", c), {31'b0, pready_w}, (c == 3) ? 32'd1 : 32'd0);
        end
        next_cycle();
        psel_w = 1'b0;
        @(negedge PCLK);
        check("ws_idle_penable", {31'b0, penable_w}, 32'd0);
        next_cycle();
        psel_w = 1'b1; transfer_w = 1'b1; pwrite_w = 1'b0;
        next_cycle();
        transfer_w = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            @(negedge PCLK);
            check($sformatf("ws_rd_pready_c%0d", c), {31'b0, pready_w}, (c == 3) ? 32'd1 : 32'd0);
        end
        check("ws_rd_data", prdata1_w, 32'hDEADBEEF);
        next_cycle();
        psel_w = 1'b0;
        next_cycle();

        // T6: out-of-range write/read, then full memory scan
        write0(32'h40, 32'h12345678);
        read0(32'h40, 32'h0);
        for (int i = 0; i < 16; i++) begin
            read0(32'(i * 4), model[i]);
        end

        // T6: reset asserted during ACCESS aborts the write and clears memory
        psel = 1'b1; transfer = 1'b1; pwrite = 1'b1; paddr = 32'h20; pdata = 32'hAAAA5555;
        next_cycle();
        transfer = 1'b0;
        next_cycle();
        @(negedge PCLK);
        check("abort_pre_penable", {31'b0, penable}, 32'd1);
        PRESET = 1'b1;
        #1;
        check("abort_penable", {31'b0, penable}, 32'd0);
        check("abort_pready", {31'b0, pready}, 32'd0);
        check("abort_prwaddr", prwaddr, 32'h0);
        next_cycle();
        PRESET = 1'b0;
        psel = 1'b0;
        @(negedge PCLK);
        check("abort_idle_penable", {31'b0, penable}, 32'd0);
        next_cycle();
        read0(32'h0, 32'h0);
        read0(32'h4, 32'h0);
        read0(32'h20, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
